fetch_cycle_hs: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline; produces the IF/ID pipeline register consumed by the decode stage (InstrD, PCD, PCPlus4D).
- Issues one instruction-memory request at a time over a valid/ready request channel and accepts a valid-only response channel.
- Honours decode stall using a 1-entry hold buffer.
- Applies branch/jump redirects from execute, flushing IF/ID and discarding any in-flight response.

---
 rtl/fetch_cycle_hs.sv | 128 ++++++++++++
 tb/tb_fetch_cycle_hs.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_cycle_hs.sv
// RV32I instruction-fetch stage: single-outstanding imem request/response handshake,
// 1-entry hold buffer for decode stalls, and redirect-driven flush of the IF/ID register.
module fetch_cycle_hs #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   localparam logic [1:0] ST_REQ   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]  state;
   logic [31:0] pcf;
   logic [31:0] pc_inflight;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;
   logic        handshake;
   logic        deliver;
   logic [31:0] dlv_instr;
   logic [31:0] dlv_pc;

   assign imem_req_valid = rst && (state == ST_REQ) && !PCSrcE;
   assign imem_req_addr  = pcf;
   assign handshake      = imem_req_valid && imem_req_ready;

   // A delivery comes either straight from the response or from the hold buffer.
   always_comb begin
      deliver   = 1'b0;
      dlv_instr = hold_instr;
      dlv_pc    = hold_pc;
      if (!PCSrcE && !StallD) begin
         if (state == ST_WAIT && imem_rsp_valid) begin
            deliver   = 1'b1;
            dlv_instr = imem_rsp_data;
            dlv_pc    = pc_inflight;
         end else if (state == ST_HOLD) begin
            deliver   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_REQ;
         pcf         <= RESET_PC;
         pc_inflight <= '0;
         hold_instr  <= '0;
         hold_pc     <= '0;
      end else begin
         case (state)
            ST_REQ: begin
               if (PCSrcE) begin
                  pcf <= PCTargetE;
               end else if (handshake) begin
                  pc_inflight <= pcf;
                  pcf         <= pcf + 32'd4;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (PCSrcE) begin
                  pcf   <= PCTargetE;
                  state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
               end else if (imem_rsp_valid) begin
                  if (StallD) begin
                     hold_instr <= imem_rsp_data;
                     hold_pc    <= pc_inflight;
                     state      <= ST_HOLD;
                  end else begin
                     state      <= ST_REQ;
                  end
               end
            end
            ST_HOLD: begin
               if (PCSrcE) begin
                  pcf   <= PCTargetE;
                  state <= ST_REQ;
               end else if (!StallD) begin
                  state <= ST_REQ;
               end
            end
            default: begin
               if (PCSrcE) pcf <= PCTargetE;
               if (imem_rsp_valid) state <= ST_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (PCSrcE) begin
         InstrD   <= NOP_INSTR;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         if (deliver) begin
            InstrD   <= dlv_instr;
            PCD      <= dlv_pc;
            PCPlus4D <= dlv_pc + 32'd4;
            ValidD   <= 1'b1;
         end else begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_cycle_hs.sv
// Randomized bench for fetch_cycle_hs: a transaction-level model (outstanding request,
// hold buffer, IF/ID) plus an instruction-memory responder with variable latency.
module tb_fetch_cycle_hs;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        StallD = 1'b0;
   logic        PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   fetch_cycle_hs #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk), .rst(rst), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .InstrD(InstrD), .PCD(PCD),
      .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: what is outstanding, what is buffered, and what IF/ID should show.
   logic [31:0] m_pcf;
   logic        m_out, m_dead, m_buf;
   logic [31:0] m_out_pc, m_buf_i, m_buf_pc;
   logic [31:0] e_instr, e_pcd, e_pc4;
   logic        e_valid;

   // Memory responder state
   logic        mem_busy;
   int unsigned mem_wait;
   logic [31:0] mem_data_q;
   int unsigned lat_max = 0;
   bit          rand_data = 1'b0;

   task automatic model_reset();
      m_pcf = RESET_PC; m_out = 1'b0; m_dead = 1'b0; m_buf = 1'b0;
      m_out_pc = '0; m_buf_i = '0; m_buf_pc = '0;
      e_instr = NOP_INSTR; e_pcd = '0; e_pc4 = '0; e_valid = 1'b0;
      mem_busy = 1'b0; mem_wait = 0; mem_data_q = '0;
   endtask

   task automatic cycle(input logic st, input logic ps, input logic [31:0] tg, input logic rd);
      logic        req_v, dlv;
      logic [31:0] di, dp;
      logic [31:0] n_pcf, n_out_pc, n_buf_i, n_buf_pc;
      logic        n_out, n_dead, n_buf;
      StallD = st; PCSrcE = ps; PCTargetE = tg; imem_req_ready = rd;
      imem_rsp_valid = mem_busy && (mem_wait == 0);
      imem_rsp_data  = imem_rsp_valid ? mem_data_q : $urandom;
      req_v = !m_out && !m_buf && !ps;
      @(negedge clk);
      chk("req_valid", {31'd0, imem_req_valid}, {31'd0, req_v});
      if (req_v) chk("req_addr", imem_req_addr, m_pcf);
      chk("InstrD", InstrD, e_instr);
      chk("PCD", PCD, e_pcd);
      chk("PCPlus4D", PCPlus4D, e_pc4);
      chk("ValidD", {31'd0, ValidD}, {31'd0, e_valid});

      dlv = 1'b0; di = '0; dp = '0;
      n_pcf = m_pcf; n_out = m_out; n_dead = m_dead; n_out_pc = m_out_pc;
      n_buf = m_buf; n_buf_i = m_buf_i; n_buf_pc = m_buf_pc;
      if (!m_out && !m_buf) begin
         if (ps) n_pcf = tg;
         else if (rd) begin
            n_out = 1'b1; n_dead = 1'b0; n_out_pc = m_pcf; n_pcf = m_pcf + 32'd4;
         end
      end else if (m_out) begin
         if (imem_rsp_valid) begin
            n_out = 1'b0;
            if (!m_dead && !ps) begin
               if (st) begin n_buf = 1'b1; n_buf_i = imem_rsp_data; n_buf_pc = m_out_pc; end
               else begin dlv = 1'b1; di = imem_rsp_data; dp = m_out_pc; end
            end
         end else if (ps) n_dead = 1'b1;
         if (ps) n_pcf = tg;
      end else begin
         if (ps) begin n_buf = 1'b0; n_pcf = tg; end
         else if (!st) begin dlv = 1'b1; di = m_buf_i; dp = m_buf_pc; n_buf = 1'b0; end
      end

      if (ps) begin e_valid = 1'b0; e_instr = NOP_INSTR; end
      else if (!st) begin
         if (dlv) begin e_valid = 1'b1; e_instr = di; e_pcd = dp; e_pc4 = dp + 32'd4; end
         else begin e_valid = 1'b0; e_instr = NOP_INSTR; end
      end

      if (imem_rsp_valid) mem_busy = 1'b0;
      else if (mem_busy) mem_wait--;
      if (req_v && rd) begin
         mem_busy   = 1'b1;
         mem_wait   = $urandom_range(lat_max, 0);
         mem_data_q = rand_data ? $urandom : (m_pcf ^ 32'hA5A5_0000);
      end

      m_pcf = n_pcf; m_out = n_out; m_dead = n_dead; m_out_pc = n_out_pc;
      m_buf = n_buf; m_buf_i = n_buf_i; m_buf_pc = n_buf_pc;
      @(posedge clk); #1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
      chk("rst_InstrD", InstrD, NOP_INSTR);
      chk("rst_PCD", PCD, 32'd0);
      chk("rst_PCPlus4D", PCPlus4D, 32'd0);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Stream with one-cycle memory, then request backpressure at PCF=0x8
      repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, '0, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
      // Stall across the 0xC response
      repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
      repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);
      // Redirect while 0x14 is in flight
      cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
      repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);
      // Redirect during a stall with the hold buffer full
      cycle(1'b0, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
      repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);
      // Address wrap at the top of the address space
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, '0, 1'b1);

      // Async reset while a request is outstanding
      for (int i = 0; i < 4 && !m_out; i++) cycle(1'b0, 1'b0, '0, 1'b1);
      chk("pre_rst_inflight", {31'd0, m_out}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_ValidD", {31'd0, ValidD}, 32'd0);
      chk("arst_InstrD", InstrD, NOP_INSTR);
      chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      model_reset();
      imem_rsp_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      PCSrcE = 1'b0;
      #1 chk("arst_req_addr", imem_req_addr, RESET_PC);
      cycle(1'b0, 1'b0, '0, 1'b1);

      // Randomized traffic
      lat_max = 2;
      rand_data = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] tg;
         tg = ($urandom_range(15, 0) == 0) ? 32'hFFFF_FFFC : {$urandom_range(32'h3FFF, 0), 2'b00};
         cycle($urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0, tg, $urandom_range(9, 0) < 7);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
